// File: rtl/mult_share_arbiter.sv
// Round-robin share of one fixed-latency sequential multiplier between two requesters.
// Latency: accept in A, m_start in A+1, rsp_valid in A+MULT_LAT+2.
// Backpressure: readys only in IDLE; one operation in flight, requester holds valid until ready.
module mult_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MULT_LAT = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               m_start,
    output logic [WIDTH-1:0]   m_a,
    output logic [WIDTH-1:0]   m_b,
    input  logic [2*WIDTH-1:0] m_p,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_p,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic       grant;
    logic       lat_id;
    logic       xfer;
    logic [3:0] cnt;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    assign req0_ready = (state == IDLE) && !clr && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && !clr && req1_valid &&  grant;
    assign xfer       = req0_ready | req1_ready;

    assign m_start   = (state == ISSUE) && !clr;
    assign rsp_valid = (state == DONE)  && !clr;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            cnt        <= 4'd0;
            m_a        <= '0;
            m_b        <= '0;
            rsp_id     <= 1'b0;
            rsp_p      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // m_a/m_b double as the operand latch so they are stable in ISSUE.
                    if (xfer) begin
                        m_a    <= grant ? req1_a : req0_a;
                        m_b    <= grant ? req1_b : req0_b;
                        lat_id <= grant;
                    end
                end
                ISSUE: cnt <= 4'(MULT_LAT - 1);
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_p  <= m_p;
                        rsp_id <= lat_id;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: last_grant <= lat_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized scoreboard bench for mult_share_arbiter with a fixed-latency multiplier model.
module tb_mult_share_arbiter;
    localparam int W = 4;
    localparam int L = 5;

    logic         clk = 1'b0;
    logic         clr;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         m_start;
    logic [W-1:0] m_a, m_b;
    logic [2*W-1:0] m_p;
    logic         rsp_valid, rsp_id, busy;
    logic [2*W-1:0] rsp_p;

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(W), .MULT_LAT(L)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_p(m_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic clr_at_edge = 1'b0;

    logic [7:0] opq0[$];
    logic [7:0] opq1[$];
    logic [8:0] sbq[$];
    logic [7:0] stq[$];
    int         idlog[$];
    logic       xfer0 = 1'b0, xfer1 = 1'b0;
    logic       drop_en = 1'b0;

    int   acc_cyc  = -1000;
    int   free_cyc = 0;
    logic last_m   = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        clr_at_edge <= clr;
    end

    // Multiplier model: product appears exactly L cycles after the start cycle, garbage otherwise.
    logic [7:0] mprod;
    int         mcnt;
    always @(posedge clk) begin
        if (clr) begin
            mcnt <= 0;
            m_p  <= '0;
        end else begin
            if (mcnt == L - 1) m_p <= mprod;
            else               m_p <= 8'($urandom);
            if (m_start) begin
                mprod <= {4'b0, m_a} * {4'b0, m_b};
                mcnt  <= 1;
            end else if (mcnt == L - 1) begin
                mcnt <= 0;
            end else if (mcnt != 0) begin
                mcnt <= mcnt + 1;
            end
        end
    end

    // Requester drivers: hold valid and operands until transfer; scramble operands when idle.
    always @(posedge clk) begin
        logic dr0, dr1;
        #1;
        dr0 = 1'b0;
        dr1 = 1'b0;
        if (xfer0 && opq0.size() > 0) void'(opq0.pop_front());
        else if (drop_en && req0_valid && opq0.size() > 0 && $urandom_range(0, 7) == 0) begin
            void'(opq0.pop_front());
            dr0 = 1'b1;
        end
        if (xfer1 && opq1.size() > 0) void'(opq1.pop_front());
        else if (drop_en && req1_valid && opq1.size() > 0 && $urandom_range(0, 7) == 0) begin
            void'(opq1.pop_front());
            dr1 = 1'b1;
        end
        xfer0 = 1'b0;
        xfer1 = 1'b0;
        if (opq0.size() > 0 && !dr0) begin
            req0_valid = 1'b1;
            {req0_a, req0_b} = opq0[0];
        end else begin
            req0_valid = 1'b0;
            {req0_a, req0_b} = 8'($urandom);
        end
        if (opq1.size() > 0 && !dr1) begin
            req1_valid = 1'b1;
            {req1_a, req1_b} = opq1[0];
        end else begin
            req1_valid = 1'b0;
            {req1_a, req1_b} = 8'($urandom);
        end
    end

    // Monitor + reference model: one operation at a time, next accept L+3 cycles after the last.
    always @(negedge clk) begin
        logic       fr, e0, e1, es, er, eb;
        logic [7:0] ab, pe;
        logic [8:0] s;
        if (clr_at_edge) begin
            chk("rst_m_a", m_a, 0);
            chk("rst_m_b", m_b, 0);
            chk("rst_rsp_p", rsp_p, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_m_start", m_start, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end
        es = (cyc == acc_cyc + 1) && !clr;
        chk("m_start", m_start, es);
        if (m_start && stq.size() > 0) begin
            ab = stq.pop_front();
            chk("m_a", m_a, ab[7:4]);
            chk("m_b", m_b, ab[3:0]);
        end
        er = (cyc == acc_cyc + L + 2) && !clr;
        chk("rsp_valid", rsp_valid, er);
        if (rsp_valid) begin
            if (sbq.size() > 0) begin
                s = sbq.pop_front();
                chk("rsp_id", rsp_id, s[8]);
                chk("rsp_p", rsp_p, s[7:0]);
                idlog.push_back(rsp_id);
            end else begin
                chk("rsp_unexpected", 1, 0);
            end
        end
        eb = (cyc > acc_cyc) && (cyc <= acc_cyc + L + 2);
        chk("busy", busy, eb);

        fr = (cyc >= free_cyc) && !clr;
        e0 = fr && req0_valid && (!req1_valid || last_m);
        e1 = fr && req1_valid && (!req0_valid || !last_m);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("one_ready", req0_ready & req1_ready, 0);
        if (e0 || e1) begin
            ab = e1 ? {req1_a, req1_b} : {req0_a, req0_b};
            pe = {4'b0, ab[7:4]} * {4'b0, ab[3:0]};
            acc_cyc  = cyc;
            free_cyc = cyc + L + 3;
            last_m   = e1;
            sbq.push_back({e1, pe});
            stq.push_back(ab);
        end
        xfer0 = req0_valid & req0_ready;
        xfer1 = req1_valid & req1_ready;
        if (clr) begin
            acc_cyc  = -1000;
            free_cyc = cyc + 1;
            last_m   = 1'b1;
            sbq.delete();
            stq.delete();
        end
    end

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((opq0.size() > 0 || opq1.size() > 0 || sbq.size() > 0 || busy ||
                req0_valid || req1_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_accept(input logic id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? (req1_valid & req1_ready) : (req0_valid & req0_ready)) && n < 100);
        if (n >= 100) chk("accept_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $finish;
    end

    initial begin
        clr = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        opq0.push_back({4'd3, 4'd5});
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        wait_idle(200);

        pulse_clr();
        @(negedge clk);
        idlog.delete();
        opq0.push_back({4'd15, 4'd15});
        opq1.push_back({4'd7, 4'd9});
        wait_idle(200);
        chk("tie_count", idlog.size(), 2);
        if (idlog.size() == 2) begin
            chk("tie_first_id", idlog[0], 0);
            chk("tie_second_id", idlog[1], 1);
        end

        idlog.delete();
        repeat (2) begin
            opq0.push_back(8'($urandom));
            opq1.push_back(8'($urandom));
        end
        wait_idle(300);
        chk("fair_count", idlog.size(), 4);
        for (int i = 0; i < idlog.size() && i < 4; i++) chk("fair_id", idlog[i], i % 2);

        idlog.delete();
        opq0.push_back(8'($urandom));
        wait_accept(1'b0);
        repeat (4) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        opq1.push_back({4'd2, 4'd4});
        wait_idle(200);
        chk("abort_rsp_count", idlog.size(), 1);
        if (idlog.size() == 1) chk("abort_next_id", idlog[0], 1);

        opq0.push_back({4'd0, 4'd9});
        wait_idle(200);

        opq1.push_back(8'($urandom));
        wait_accept(1'b1);
        opq0.push_back(8'($urandom));
        repeat (2) @(negedge clk);
        void'(opq0.pop_front());
        wait_idle(200);

        drop_en = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) opq0.push_back(8'($urandom));
            if ($urandom_range(0, 11) == 0) opq1.push_back(8'($urandom));
        end
        wait_idle(3000);
        drop_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
